// File: rtl/hazard_ctrl.sv
//============================================================================
// Module   : hazard_ctrl
// Purpose  : Parametrised stall/flush controller for the pipelined MIPS core.
//            Optional performance counters are built when HAZARD_PERF_EN is
//            defined; otherwise stall_cnt/flush_cnt are tied to zero.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int NSTAGES      = 5,
    parameter int LOAD_USE_CYC = 1,
    parameter int BR_RESOLVE   = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 dmemREN,
    input  logic                 dmemWEN,
    input  logic                 halt,
    input  logic                 redirect,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic [4:0]           ex_rt,
    input  logic                 ex_load,
    output logic                 pc_wen,
    output logic [NSTAGES-2:0]   latch_wen,
    output logic [NSTAGES-2:0]   latch_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int L = NSTAGES - 1;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LU   = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [L-1:0] c_BR_MASK = {L{1'b1}} >> (L - BR_RESOLVE);
    localparam logic [2:0]   c_LU_INIT = 3'(LOAD_USE_CYC - 1);

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [1:0] w_state_nx;
    logic [2:0] w_cnt_nx;
    logic       w_dstall;
    logic       w_lu;

    assign w_dstall = (dmemREN | dmemWEN) & ~dhit;
    assign w_lu     = ex_load & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_comb begin
        pc_wen      = 1'b1;
        latch_wen   = '1;
        latch_flush = '0;
        halted      = (r_state == S_HALT);
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        if (!nRST) begin
            pc_wen      = 1'b0;
            latch_wen   = '0;
            latch_flush = '1;
            halted      = 1'b0;
        end else if (r_state == S_HALT) begin
            pc_wen    = 1'b0;
            latch_wen = '0;
        end else if (w_dstall) begin
            // Whole pipe frozen; redirect/halt stay asserted until released.
            pc_wen    = 1'b0;
            latch_wen = '0;
        end else if (halt) begin
            pc_wen     = 1'b0;
            latch_wen  = '0;
            w_state_nx = S_HALT;
            w_cnt_nx   = 3'd0;
        end else if (redirect) begin
            latch_flush = c_BR_MASK;
            w_state_nx  = S_RUN;
            w_cnt_nx    = 3'd0;
        end else if ((r_state == S_LU) || w_lu) begin
            pc_wen         = 1'b0;
            latch_wen[0]   = 1'b0;
            latch_flush[1] = 1'b1;
            if (r_state == S_LU) begin
                if (r_cnt <= 3'd1) begin
                    w_state_nx = S_RUN;
                    w_cnt_nx   = 3'd0;
                end else begin
                    w_cnt_nx = r_cnt - 3'd1;
                end
            end else if (LOAD_USE_CYC > 1) begin
                w_state_nx = S_LU;
                w_cnt_nx   = c_LU_INIT;
            end
        end else if (!ihit) begin
            pc_wen         = 1'b0;
            latch_flush[0] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

`ifdef HAZARD_PERF_EN
    logic w_stall_evt;
    logic w_flush_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_stall_evt = (r_state != S_HALT) & (w_dstall | w_lu | (r_state == S_LU));
    assign w_flush_evt = (r_state != S_HALT) & ~w_dstall & ~halt & redirect;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl; two parameterisations share
//            one stimulus stream and are checked against a behavioural model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       ihit, dhit, ren, wen, halt, redir, exload;
        logic [4:0] rs, rt, exrt;
    } in_t;

    typedef struct packed {
        logic        pc;
        logic [3:0]  wen;
        logic [3:0]  fl;
        logic        h;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    logic ihit, dhit, ren, wen, halt, redir, exload;
    logic [4:0] rs, rt, exrt;

    logic        pc_a, pc_b, h_a, h_b;
    logic [3:0]  wen_a, wen_b, fl_a, fl_b;
    logic [15:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    int checks = 0;
    int errors = 0;

    exp_t q_exp[2][$];

    // Model state: remaining bubble cycles after the current one, sticky halt, counters
    int m_rem[2];
    bit m_halt[2];
    int m_sc[2];
    int m_fc[2];
    int luc[2]  = '{1, 3};
    int brr[2]  = '{1, 2};
    int cmax[2] = '{65535, 15};

    always #5 clk = ~clk;

    hazard_ctrl #(.NSTAGES(5), .LOAD_USE_CYC(1), .BR_RESOLVE(1), .CNT_W(16)) u_a (
        .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit), .dmemREN(ren), .dmemWEN(wen),
        .halt(halt), .redirect(redir), .id_rs(rs), .id_rt(rt), .ex_rt(exrt), .ex_load(exload),
        .pc_wen(pc_a), .latch_wen(wen_a), .latch_flush(fl_a), .halted(h_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_ctrl #(.NSTAGES(5), .LOAD_USE_CYC(3), .BR_RESOLVE(2), .CNT_W(4)) u_b (
        .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit), .dmemREN(ren), .dmemWEN(wen),
        .halt(halt), .redirect(redir), .id_rs(rs), .id_rt(rt), .ex_rt(exrt), .ex_load(exload),
        .pc_wen(pc_b), .latch_wen(wen_b), .latch_flush(fl_b), .halted(h_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.ihit = 1'b1;
        s.dhit = 1'b1;
        return s;
    endfunction

    task automatic model(input int i, input in_t s, input logic nr, output exp_t e);
        bit dst, lu;
        e = '0;
        if (!nr) begin
            e.fl = 4'hF;
            m_rem[i] = 0; m_halt[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            return;
        end
        dst = (s.ren || s.wen) && !s.dhit;
        lu  = s.exload && (s.exrt != 0) && (s.exrt == s.rs || s.exrt == s.rt);
        e.h  = m_halt[i];
        e.sc = PERF ? 16'(m_sc[i]) : 16'd0;
        e.fc = PERF ? 16'(m_fc[i]) : 16'd0;
        if (!m_halt[i]) begin
            if ((dst || lu || m_rem[i] > 0) && m_sc[i] < cmax[i]) m_sc[i]++;
            if (!dst && !s.halt && s.redir && m_fc[i] < cmax[i]) m_fc[i]++;
        end
        if (m_halt[i] || dst) begin
            e.pc = 0; e.wen = 4'h0; e.fl = 4'h0;
        end else if (s.halt) begin
            e.pc = 0; e.wen = 4'h0; e.fl = 4'h0;
            m_halt[i] = 1; m_rem[i] = 0;
        end else if (s.redir) begin
            e.pc = 1; e.wen = 4'hF; e.fl = 4'((1 << brr[i]) - 1);
            m_rem[i] = 0;
        end else if (m_rem[i] > 0 || lu) begin
            e.pc = 0; e.wen = 4'b1110; e.fl = 4'b0010;
            if (m_rem[i] > 0) m_rem[i]--;
            else m_rem[i] = luc[i] - 1;
        end else if (!s.ihit) begin
            e.pc = 0; e.wen = 4'hF; e.fl = 4'b0001;
        end else begin
            e.pc = 1; e.wen = 4'hF; e.fl = 4'h0;
        end
    endtask

    task automatic apply(input in_t s);
        exp_t e;
        {ihit, dhit, ren, wen, halt, redir, exload} =
            {s.ihit, s.dhit, s.ren, s.wen, s.halt, s.redir, s.exload};
        rs = s.rs; rt = s.rt; exrt = s.exrt;
        for (int i = 0; i < 2; i++) begin
            model(i, s, nrst, e);
            q_exp[i].push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    exp_t act_a, act_b, ea, eb;
    always @(negedge clk) begin
        act_a = {pc_a, wen_a, fl_a, h_a, sc_a, fc_a};
        act_b = {pc_b, wen_b, fl_b, h_b, 12'd0, sc_b, 12'd0, fc_b};
        if (q_exp[0].size() > 0) begin
            ea = q_exp[0].pop_front();
            checks++;
            if (act_a !== ea) begin
                errors++;
                $display("FAIL cfgA t=%0t got pc=%b wen=%b fl=%b h=%b sc=%0d fc=%0d exp pc=%b wen=%b fl=%b h=%b sc=%0d fc=%0d",
                         $time, act_a.pc, act_a.wen, act_a.fl, act_a.h, act_a.sc, act_a.fc,
                         ea.pc, ea.wen, ea.fl, ea.h, ea.sc, ea.fc);
            end
        end
        if (q_exp[1].size() > 0) begin
            eb = q_exp[1].pop_front();
            checks++;
            if (act_b !== eb) begin
                errors++;
                $display("FAIL cfgB t=%0t got pc=%b wen=%b fl=%b h=%b sc=%0d fc=%0d exp pc=%b wen=%b fl=%b h=%b sc=%0d fc=%0d",
                         $time, act_b.pc, act_b.wen, act_b.fl, act_b.h, act_b.sc, act_b.fc,
                         eb.pc, eb.wen, eb.fl, eb.h, eb.sc, eb.fc);
            end
        end
    end

    initial begin
        in_t s;
        nrst = 1'b0;
        s = idle();
        {ihit, dhit, ren, wen, halt, redir, exload} = 7'b1100000;
        rs = 0; rt = 0; exrt = 0;
        @(posedge clk);
        #1;
        apply(s);
        apply(s);
        nrst = 1'b1;
        apply(idle());

        // Load-use on rs
        s = idle(); s.exload = 1; s.exrt = 5; s.rs = 5;
        apply(s);
        repeat (4) apply(idle());

        // Load-use on rt with a data stall in the second bubble
        s = idle(); s.exload = 1; s.exrt = 7; s.rt = 7;
        apply(s);
        s = idle(); s.ren = 1; s.dhit = 0;
        apply(s);
        repeat (4) apply(idle());

        // r0 is exempt
        s = idle(); s.exload = 1; s.exrt = 0; s.rs = 0;
        apply(s);

        // Redirect overrides load-use, ihit low
        s = idle(); s.exload = 1; s.exrt = 3; s.rs = 3; s.redir = 1; s.ihit = 0;
        apply(s);
        apply(idle());

        // Redirect frozen by data stall for two cycles
        s = idle(); s.redir = 1; s.ren = 1; s.dhit = 0;
        apply(s);
        apply(s);
        s.dhit = 1;
        apply(s);
        s = idle(); s.ihit = 0;
        apply(s);
        apply(idle());

        // Halt is sticky
        s = idle(); s.halt = 1;
        apply(s);
        for (int k = 0; k < 5; k++) begin
            s = in_t'($urandom);
            apply(s);
        end

        // Reset in the middle of a multi-cycle bubble
        nrst = 1'b0;
        apply(idle());
        nrst = 1'b1;
        s = idle(); s.exload = 1; s.exrt = 9; s.rs = 9;
        apply(s);
        apply(idle());
        nrst = 1'b0;
        apply(idle());
        nrst = 1'b1;
        repeat (2) apply(idle());

        for (int k = 0; k < 3000; k++) begin
            s.ihit   = ($urandom_range(0, 9) < 8);
            s.dhit   = ($urandom_range(0, 9) < 6);
            s.ren    = ($urandom_range(0, 3) == 0);
            s.wen    = ($urandom_range(0, 3) == 0);
            s.halt   = ($urandom_range(0, 49) == 0);
            s.redir  = ($urandom_range(0, 7) == 0);
            s.exload = ($urandom_range(0, 1) == 1);
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.exrt   = 5'($urandom_range(0, 3));
            nrst     = ($urandom_range(0, 59) != 0);
            apply(s);
        end
        nrst = 1'b1;
        apply(idle());

        @(negedge clk);
        #1;
        if (q_exp[0].size() != 0 || q_exp[1].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d/%0d entries left, exp 0", q_exp[0].size(), q_exp[1].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
